// File: rtl/hazard_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// hazard_ctrl_pkg
// Shared types and constants for the pipeline hazard controller.
//   REG_W      : width of an architectural register index
//   XZR_IDX    : index of the zero register, which never creates a hazard
//   slot_t     : one shadow-scoreboard entry {valid, rd, regwrite, memread}
//   SLOT_EMPTY : an invalid entry, used for reset, bubbles and squashes
//   slot_hits  : true when a shadow entry produces a value the consumer reads
// ---------------------------------------------------------------------------
package hazard_ctrl_pkg;

    localparam int REG_W = 5;
    localparam logic [REG_W-1:0] XZR_IDX = 5'd31;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rd;
        logic             regwrite;
        logic             memread;
    } slot_t;

    localparam slot_t SLOT_EMPTY = '0;

    // A write to the zero register is discarded by the register file,
    // so it can never be the source of a read-after-write dependency.
    function automatic logic slot_hits(input slot_t s,
                                       input logic [REG_W-1:0] src,
                                       input logic used);
        return used && s.valid && s.regwrite && (s.rd == src) && (s.rd != XZR_IDX);
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// hazard_ctrl_if
// Bundles the ID-stage operand information, the MEM-stage branch outcome and
// the pipeline-register control outputs of the hazard controller.
//   master : the pipeline side (drives id_* / mem_branch_taken, reads controls)
//   slave  : the hazard controller itself
// Parameter CNT_W sets the width of the two performance counters.
// ---------------------------------------------------------------------------
interface hazard_ctrl_if #(parameter int CNT_W = 32);
    import hazard_ctrl_pkg::*;

    logic [REG_W-1:0] id_rf1;
    logic [REG_W-1:0] id_rf2;
    logic             id_rf1_used;
    logic             id_rf2_used;
    logic [REG_W-1:0] id_rd;
    logic             id_regwrite;
    logic             id_memread;
    logic             mem_branch_taken;

    logic             pc_write_en;
    logic             ifid_write_en;
    logic             ifid_flush;
    logic             idex_bubble;
    logic             exmem_flush;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;

    modport master (
        output id_rf1, id_rf2, id_rf1_used, id_rf2_used,
               id_rd, id_regwrite, id_memread, mem_branch_taken,
        input  pc_write_en, ifid_write_en, ifid_flush, idex_bubble,
               exmem_flush, stall_count, flush_count
    );

    modport slave (
        input  id_rf1, id_rf2, id_rf1_used, id_rf2_used,
               id_rd, id_regwrite, id_memread, mem_branch_taken,
        output pc_write_en, ifid_write_en, ifid_flush, idex_bubble,
               exmem_flush, stall_count, flush_count
    );

endinterface

// File: rtl/hazard_ctrl_slot.sv
// ---------------------------------------------------------------------------
// hazard_slot
// One shadow-scoreboard entry mirroring a pipeline register.
//   clk       : rising-edge clock
//   reset     : asynchronous active-high reset, empties the entry
//   clear     : load an invalid entry at the next edge (bubble / squash)
//   load_slot : entry arriving from the previous stage
//   slot_q    : current contents
// ---------------------------------------------------------------------------
module hazard_slot
    import hazard_ctrl_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  clear,
    input  slot_t load_slot,
    output slot_t slot_q
);

    slot_t slot_d;

    always_comb begin
        slot_d = load_slot;
        if (clear) begin
            slot_d = SLOT_EMPTY;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_q <= SLOT_EMPTY;
        end else begin
            slot_q <= slot_d;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
// Decides when ID/EX receives a bubble and when PC and IF/ID are frozen or
// flushed. A shadow scoreboard of the EX/MEM/WB destinations is compared
// against the ID operands; taken branches resolved in MEM squash the younger
// instructions. All control outputs are combinational (zero latency).
// Parameters:
//   FORWARDING : 1 = stall only on load-use, 0 = stall on any EX/MEM/WB RAW
//   RF_BYPASS  : 1 = register file writes before reads, WB never stalls
//   CNT_W      : performance counter width (wraps modulo 2^CNT_W)
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : hazard_ctrl_if slave (ID operands, branch, controls, counters)
// ---------------------------------------------------------------------------
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter bit FORWARDING = 1'b1,
    parameter bit RF_BYPASS  = 1'b1,
    parameter int CNT_W      = 32
) (
    input logic         clk,
    input logic         reset,
    hazard_ctrl_if.slave bus
);

    slot_t ex_d;
    slot_t ex_q;
    slot_t mem_q;
    slot_t wb_q;

    logic ex_hit;
    logic mem_hit;
    logic wb_hit;
    logic stall;
    logic branch;

    logic pc_write_en;
    logic ifid_write_en;
    logic ifid_flush;
    logic idex_bubble;
    logic exmem_flush;

    logic [CNT_W-1:0] stall_count_d;
    logic [CNT_W-1:0] stall_count_q;
    logic [CNT_W-1:0] flush_count_d;
    logic [CNT_W-1:0] flush_count_q;

    // Entry describing the ID instruction as it would enter EX.
    always_comb begin
        ex_d          = SLOT_EMPTY;
        ex_d.valid    = 1'b1;
        ex_d.rd       = bus.id_rd;
        ex_d.regwrite = bus.id_regwrite;
        ex_d.memread  = bus.id_memread;
    end

    // Shadow scoreboard: EX is bubbled with ID/EX, MEM is squashed with
    // EX/MEM, WB simply follows MEM.
    hazard_slot u_ex_slot (
        .clk       (clk),
        .reset     (reset),
        .clear     (idex_bubble),
        .load_slot (ex_d),
        .slot_q    (ex_q)
    );

    hazard_slot u_mem_slot (
        .clk       (clk),
        .reset     (reset),
        .clear     (exmem_flush),
        .load_slot (ex_q),
        .slot_q    (mem_q)
    );

    hazard_slot u_wb_slot (
        .clk       (clk),
        .reset     (reset),
        .clear     (1'b0),
        .load_slot (mem_q),
        .slot_q    (wb_q)
    );

    // Dependency detection. With forwarding only a load still in EX cannot
    // supply its value in time; without it every in-flight producer stalls,
    // except the WB one when the register file bypasses write to read.
    always_comb begin
        ex_hit  = slot_hits(ex_q,  bus.id_rf1, bus.id_rf1_used) ||
                  slot_hits(ex_q,  bus.id_rf2, bus.id_rf2_used);
        mem_hit = slot_hits(mem_q, bus.id_rf1, bus.id_rf1_used) ||
                  slot_hits(mem_q, bus.id_rf2, bus.id_rf2_used);
        wb_hit  = slot_hits(wb_q,  bus.id_rf1, bus.id_rf1_used) ||
                  slot_hits(wb_q,  bus.id_rf2, bus.id_rf2_used);
        if (FORWARDING) begin
            stall = ex_hit && ex_q.memread;
        end else begin
            stall = ex_hit || mem_hit || (wb_hit && !RF_BYPASS);
        end
        branch = bus.mem_branch_taken;
    end

    // Pipeline-register controls. Reset forces a frozen front end with a
    // bubble; a taken branch wins over a stall since the stalled
    // instruction is squashed anyway.
    always_comb begin
        pc_write_en   = 1'b1;
        ifid_write_en = 1'b1;
        ifid_flush    = 1'b0;
        idex_bubble   = 1'b0;
        exmem_flush   = 1'b0;
        if (reset) begin
            pc_write_en   = 1'b0;
            ifid_write_en = 1'b0;
            idex_bubble   = 1'b1;
        end else if (branch) begin
            ifid_flush    = 1'b1;
            idex_bubble   = 1'b1;
            exmem_flush   = 1'b1;
        end else if (stall) begin
            pc_write_en   = 1'b0;
            ifid_write_en = 1'b0;
            idex_bubble   = 1'b1;
        end
    end

    // Performance counters; a stall hidden under a branch is not counted.
    always_comb begin
        stall_count_d = stall_count_q;
        flush_count_d = flush_count_q;
        if (branch) begin
            flush_count_d = flush_count_q + CNT_W'(1);
        end else if (stall) begin
            stall_count_d = stall_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            stall_count_q <= stall_count_d;
            flush_count_q <= flush_count_d;
        end
    end

    assign bus.pc_write_en   = pc_write_en;
    assign bus.ifid_write_en = ifid_write_en;
    assign bus.ifid_flush    = ifid_flush;
    assign bus.idex_bubble   = idex_bubble;
    assign bus.exmem_flush   = exmem_flush;
    assign bus.stall_count   = stall_count_q;
    assign bus.flush_count   = flush_count_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl
// Drives three hazard controllers (forwarding; no forwarding with register
// file bypass; no forwarding, no bypass and a 4-bit counter) from one shared
// ID/branch stimulus and compares them with a reference model that tracks the
// last three issued instructions and applies the stall window rules.
// ---------------------------------------------------------------------------
module tb_hazard_ctrl;
    import hazard_ctrl_pkg::*;

    localparam int NCFG = 3;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [4:0] rf1, rf2, rd;
    logic       u1, u2, rw, mr, br;

    hazard_ctrl_if #(.CNT_W(32)) bus_a ();
    hazard_ctrl_if #(.CNT_W(32)) bus_b ();
    hazard_ctrl_if #(.CNT_W(4))  bus_c ();

    assign bus_a.id_rf1 = rf1; assign bus_a.id_rf2 = rf2; assign bus_a.id_rf1_used = u1;
    assign bus_a.id_rf2_used = u2; assign bus_a.id_rd = rd; assign bus_a.id_regwrite = rw;
    assign bus_a.id_memread = mr; assign bus_a.mem_branch_taken = br;
    assign bus_b.id_rf1 = rf1; assign bus_b.id_rf2 = rf2; assign bus_b.id_rf1_used = u1;
    assign bus_b.id_rf2_used = u2; assign bus_b.id_rd = rd; assign bus_b.id_regwrite = rw;
    assign bus_b.id_memread = mr; assign bus_b.mem_branch_taken = br;
    assign bus_c.id_rf1 = rf1; assign bus_c.id_rf2 = rf2; assign bus_c.id_rf1_used = u1;
    assign bus_c.id_rf2_used = u2; assign bus_c.id_rd = rd; assign bus_c.id_regwrite = rw;
    assign bus_c.id_memread = mr; assign bus_c.mem_branch_taken = br;

    hazard_ctrl #(.FORWARDING(1'b1), .RF_BYPASS(1'b1), .CNT_W(32)) dut_fwd (
        .clk(clk), .reset(reset), .bus(bus_a));
    hazard_ctrl #(.FORWARDING(1'b0), .RF_BYPASS(1'b1), .CNT_W(32)) dut_byp (
        .clk(clk), .reset(reset), .bus(bus_b));
    hazard_ctrl #(.FORWARDING(1'b0), .RF_BYPASS(1'b0), .CNT_W(4)) dut_nobyp (
        .clk(clk), .reset(reset), .bus(bus_c));

    // Control vector order: {pc_write_en, ifid_write_en, ifid_flush, idex_bubble, exmem_flush}
    logic [4:0]  obs_ctl   [NCFG];
    logic [31:0] obs_stall [NCFG];
    logic [31:0] obs_flush [NCFG];

    assign obs_ctl[0] = {bus_a.pc_write_en, bus_a.ifid_write_en, bus_a.ifid_flush,
                         bus_a.idex_bubble, bus_a.exmem_flush};
    assign obs_ctl[1] = {bus_b.pc_write_en, bus_b.ifid_write_en, bus_b.ifid_flush,
                         bus_b.idex_bubble, bus_b.exmem_flush};
    assign obs_ctl[2] = {bus_c.pc_write_en, bus_c.ifid_write_en, bus_c.ifid_flush,
                         bus_c.idex_bubble, bus_c.exmem_flush};
    assign obs_stall[0] = bus_a.stall_count;
    assign obs_stall[1] = bus_b.stall_count;
    assign obs_stall[2] = {28'd0, bus_c.stall_count};
    assign obs_flush[0] = bus_a.flush_count;
    assign obs_flush[1] = bus_b.flush_count;
    assign obs_flush[2] = {28'd0, bus_c.flush_count};

    localparam logic [4:0] CTL_IDLE   = 5'b11000;
    localparam logic [4:0] CTL_STALL  = 5'b00010;
    localparam logic [4:0] CTL_BRANCH = 5'b11111;

    bit          cfg_fwd  [NCFG] = '{1'b1, 1'b0, 1'b0};
    bit          cfg_byp  [NCFG] = '{1'b1, 1'b1, 1'b0};
    logic [31:0] cnt_mask [NCFG] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_000F};

    // Reference model: the three most recently issued instructions, index 0
    // being the one just ahead of ID.
    typedef struct {
        bit         valid;
        logic [4:0] rd;
        bit         rw;
        bit         ld;
    } instr_t;

    instr_t      flight [NCFG][3];
    logic [31:0] m_stall [NCFG];
    logic [31:0] m_flush [NCFG];

    int checks = 0;
    int passes = 0;

    function automatic bit m_stalls(int c);
        bit s = 1'b0;
        for (int k = 0; k < 3; k++) begin
            instr_t p;
            bit reads;
            bit in_window;
            p = flight[c][k];
            reads = p.valid && p.rw && (p.rd != 5'd31) &&
                    ((u1 && p.rd == rf1) || (u2 && p.rd == rf2));
            in_window = cfg_fwd[c] ? (k == 0 && p.ld) : (k < 2 || !cfg_byp[c]);
            if (reads && in_window) s = 1'b1;
        end
        return s;
    endfunction

    function automatic logic [4:0] m_ctl(int c);
        if (reset) return CTL_STALL;
        if (br) return CTL_BRANCH;
        if (m_stalls(c)) return CTL_STALL;
        return CTL_IDLE;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NCFG; c++) begin
            for (int k = 0; k < 3; k++) flight[c][k] = '{1'b0, 5'd0, 1'b0, 1'b0};
            m_stall[c] = 32'd0;
            m_flush[c] = 32'd0;
        end
    endtask

    // Commits the current cycle into the model, then moves to 1 time unit
    // after the next rising edge.
    task automatic advance();
        for (int c = 0; c < NCFG; c++) begin
            bit st;
            st = m_stalls(c);
            if (br) m_flush[c] = (m_flush[c] + 32'd1) & cnt_mask[c];
            else if (st) m_stall[c] = (m_stall[c] + 32'd1) & cnt_mask[c];
            flight[c][2] = flight[c][1];
            flight[c][1] = br ? '{1'b0, 5'd0, 1'b0, 1'b0} : flight[c][0];
            flight[c][0] = (br || st) ? '{1'b0, 5'd0, 1'b0, 1'b0} : '{1'b1, rd, rw, mr};
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic [4:0] a, input logic ua, input logic [4:0] b,
                          input logic ub, input logic [4:0] d, input logic w,
                          input logic m, input logic brn);
        rf1 = a; u1 = ua; rf2 = b; u2 = ub; rd = d; rw = w; mr = m; br = brn;
    endtask

    task automatic drain();
        repeat (3) begin
            set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd31, 1'b0, 1'b0, 1'b0);
            advance();
        end
    endtask

    function automatic logic [4:0] pick_reg();
        int v;
        v = $urandom_range(0, 4);
        return (v == 4) ? 5'd31 : 5'(v);
    endfunction

    task automatic test_reset();
        @(posedge clk);
        #1;
        set_id(5'd2, 1'b1, 5'd3, 1'b1, 5'd2, 1'b1, 1'b1, 1'b1);
        #1;
        for (int c = 0; c < NCFG; c++) begin
            checks++;
            if (obs_ctl[c] !== CTL_STALL)
                $display("[TB] FAIL reset_ctl cfg%0d: got %b expected %b", c, obs_ctl[c], CTL_STALL);
            else passes++;
            checks++;
            if (obs_stall[c] !== 32'd0 || obs_flush[c] !== 32'd0)
                $display("[TB] FAIL reset_cnt cfg%0d: got %0d/%0d expected 0/0", c, obs_stall[c], obs_flush[c]);
            else passes++;
        end
        model_reset();
        reset = 1'b0;
        set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd31, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_load_use();
        logic [31:0] s0;
        logic [4:0]  want [3];
        want = '{CTL_IDLE, CTL_STALL, CTL_IDLE};
        drain();
        s0 = m_stall[0];
        for (int i = 0; i < 3; i++) begin
            if (i == 0) set_id(5'd1, 1'b1, 5'd0, 1'b0, 5'd2, 1'b1, 1'b1, 1'b0);
            else        set_id(5'd2, 1'b1, 5'd4, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0);
            #1;
            checks++;
            if (obs_ctl[0] !== want[i])
                $display("[TB] FAIL load_use cycle%0d: got %b expected %b", i, obs_ctl[0], want[i]);
            else passes++;
            for (int c = 1; c < NCFG; c++) begin
                checks++;
                if (obs_ctl[c] !== m_ctl(c))
                    $display("[TB] FAIL load_use model cfg%0d: got %b expected %b", c, obs_ctl[c], m_ctl(c));
                else passes++;
            end
            advance();
        end
        checks++;
        if (obs_stall[0] !== s0 + 32'd1)
            $display("[TB] FAIL load_use stall_count: got %0d expected %0d", obs_stall[0], s0 + 32'd1);
        else passes++;
    endtask

    task automatic test_alu_forward();
        drain();
        set_id(5'd1, 1'b1, 5'd0, 1'b0, 5'd2, 1'b1, 1'b0, 1'b0);
        advance();
        set_id(5'd2, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);
        #1;
        checks++;
        if (obs_ctl[0] !== CTL_IDLE)
            $display("[TB] FAIL alu_forward: got %b expected %b", obs_ctl[0], CTL_IDLE);
        else passes++;
        advance();
    endtask

    task automatic test_no_forward();
        logic [31:0] s0;
        logic [4:0]  want [4];
        want = '{CTL_STALL, CTL_STALL, CTL_IDLE, CTL_IDLE};
        drain();
        s0 = m_stall[1];
        set_id(5'd6, 1'b1, 5'd7, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
        advance();
        for (int i = 0; i < 4; i++) begin
            set_id(5'd5, 1'b1, 5'd5, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0);
            #1;
            checks++;
            if (obs_ctl[1] !== want[i])
                $display("[TB] FAIL no_forward cycle%0d: got %b expected %b", i, obs_ctl[1], want[i]);
            else passes++;
            checks++;
            if (obs_ctl[2] !== m_ctl(2))
                $display("[TB] FAIL no_forward nobyp cycle%0d: got %b expected %b", i, obs_ctl[2], m_ctl(2));
            else passes++;
            advance();
        end
        checks++;
        if (obs_stall[1] !== s0 + 32'd2)
            $display("[TB] FAIL no_forward stall_count: got %0d expected %0d", obs_stall[1], s0 + 32'd2);
        else passes++;
    endtask

    task automatic test_no_hazard();
        for (int scen = 0; scen < 2; scen++) begin
            drain();
            if (scen == 0) set_id(5'd1, 1'b1, 5'd0, 1'b0, 5'd31, 1'b1, 1'b1, 1'b0);
            else           set_id(5'd1, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0);
            advance();
            for (int i = 0; i < 3; i++) begin
                if (scen == 0) set_id(5'd31, 1'b1, 5'd31, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
                else           set_id(5'd8, 1'b1, 5'd7, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0);
                #1;
                for (int c = 0; c < NCFG; c++) begin
                    checks++;
                    if (obs_ctl[c] !== CTL_IDLE)
                        $display("[TB] FAIL no_hazard s%0d cfg%0d cycle%0d: got %b expected %b",
                                 scen, c, i, obs_ctl[c], CTL_IDLE);
                    else passes++;
                end
                advance();
            end
        end
    endtask

    task automatic test_branch_over_stall();
        logic [31:0] s0, f0;
        drain();
        s0 = m_stall[0];
        f0 = m_flush[0];
        set_id(5'd1, 1'b1, 5'd0, 1'b0, 5'd4, 1'b1, 1'b1, 1'b0);
        advance();
        set_id(5'd4, 1'b1, 5'd4, 1'b1, 5'd6, 1'b1, 1'b0, 1'b1);
        #1;
        for (int c = 0; c < NCFG; c++) begin
            checks++;
            if (obs_ctl[c] !== CTL_BRANCH)
                $display("[TB] FAIL branch ctl cfg%0d: got %b expected %b", c, obs_ctl[c], CTL_BRANCH);
            else passes++;
        end
        advance();
        checks++;
        if (obs_stall[0] !== s0 || obs_flush[0] !== f0 + 32'd1)
            $display("[TB] FAIL branch counters: got %0d/%0d expected %0d/%0d",
                     obs_stall[0], obs_flush[0], s0, f0 + 32'd1);
        else passes++;
        // The squashed load must be gone from every slot, even without forwarding.
        set_id(5'd4, 1'b1, 5'd4, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
        #1;
        for (int c = 0; c < NCFG; c++) begin
            checks++;
            if (obs_ctl[c] !== CTL_IDLE)
                $display("[TB] FAIL branch squash cfg%0d: got %b expected %b", c, obs_ctl[c], CTL_IDLE);
            else passes++;
        end
        advance();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            set_id(pick_reg(), 1'($urandom_range(0, 1)), pick_reg(), 1'($urandom_range(0, 1)),
                   pick_reg(), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 7) == 0));
            #1;
            for (int c = 0; c < NCFG; c++) begin
                checks++;
                if (obs_ctl[c] !== m_ctl(c))
                    $display("[TB] FAIL random ctl cfg%0d cycle%0d: got %b expected %b",
                             c, i, obs_ctl[c], m_ctl(c));
                else passes++;
            end
            advance();
            for (int c = 0; c < NCFG; c++) begin
                checks++;
                if (obs_stall[c] !== m_stall[c] || obs_flush[c] !== m_flush[c])
                    $display("[TB] FAIL random cnt cfg%0d cycle%0d: got %0d/%0d expected %0d/%0d",
                             c, i, obs_stall[c], obs_flush[c], m_stall[c], m_flush[c]);
                else passes++;
            end
        end
    endtask

    task automatic test_reset_mid_stall();
        drain();
        set_id(5'd1, 1'b1, 5'd0, 1'b0, 5'd2, 1'b1, 1'b1, 1'b0);
        advance();
        set_id(5'd2, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0);
        #1;
        checks++;
        if (obs_ctl[0] !== CTL_STALL)
            $display("[TB] FAIL mid_stall setup: got %b expected %b", obs_ctl[0], CTL_STALL);
        else passes++;
        #1;
        reset = 1'b1;
        #1;
        for (int c = 0; c < NCFG; c++) begin
            checks++;
            if (obs_ctl[c] !== CTL_STALL || obs_stall[c] !== 32'd0 || obs_flush[c] !== 32'd0)
                $display("[TB] FAIL mid_stall reset cfg%0d: got %b %0d/%0d expected %b 0/0",
                         c, obs_ctl[c], obs_stall[c], obs_flush[c], CTL_STALL);
            else passes++;
        end
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_id(5'(20 + i), 1'b1, 5'(21 + i), 1'b1, 5'(10 + i), 1'b1, 1'(i % 2), 1'b0);
            #1;
            for (int c = 0; c < NCFG; c++) begin
                checks++;
                if (obs_ctl[c] !== CTL_IDLE)
                    $display("[TB] FAIL after_reset cfg%0d cycle%0d: got %b expected %b",
                             c, i, obs_ctl[c], CTL_IDLE);
                else passes++;
            end
            advance();
        end
        for (int c = 0; c < NCFG; c++) begin
            checks++;
            if (obs_stall[c] !== 32'd0)
                $display("[TB] FAIL after_reset stall_count cfg%0d: got %0d expected 0", c, obs_stall[c]);
            else passes++;
        end
    endtask

    initial begin
        set_id(5'd0, 1'b0, 5'd0, 1'b0, 5'd31, 1'b0, 1'b0, 1'b0);
        model_reset();
        test_reset();
        test_load_use();
        test_alu_forward();
        test_no_forward();
        test_no_hazard();
        test_branch_over_stall();
        test_random();
        test_reset_mid_stall();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
